// File: rtl/slt_multicycle.sv
// slt_multicycle: multi-cycle set-less-than. A - B is formed as A + ~B + 1,
// CHUNK bits per clock (LSB chunk first), carry registered between chunks.
// Result is {WIDTH-1 zeros, lt}; ovf flags signed overflow of A - B.
// Latency N+1 cycles from accept to done (N = WIDTH/CHUNK); no input-to-output
// combinational path. Optional feature macro: SLT_UNSIGNED_EN (enables SLTU).
module slt_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_unsigned,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_nb;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

`ifdef SLT_UNSIGNED_EN
  logic             r_uns;
`else
  // Port kept for interface compatibility; the mode is always signed here.
  logic             w_unused_uns;
  assign w_unused_uns = is_unsigned;
`endif

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_nb_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_cout;
  logic             w_sign;
  logic             w_cmsb;
  logic             w_ov;
  logic             w_last;
  logic             w_accept;
  logic             w_lt;
  logic             w_ovf;

  assign w_a_chunk  = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_nb_chunk = r_nb[r_cnt*CHUNK +: CHUNK];
  assign w_sum      = {1'b0, w_a_chunk} + {1'b0, w_nb_chunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_cout     = w_sum[CHUNK];
  assign w_sign     = w_sum[CHUNK-1];
  // Carry into the top bit recovered from the sum bit: s = a ^ b ^ cin.
  assign w_cmsb     = w_a_chunk[CHUNK-1] ^ w_nb_chunk[CHUNK-1] ^ w_sign;
  assign w_ov       = w_cmsb ^ w_cout;
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_accept   = start && (r_state != S_BUSY);

`ifdef SLT_UNSIGNED_EN
  // Unsigned: no carry out of A + ~B + 1 means a borrow, i.e. A < B.
  assign w_lt  = r_uns ? ~w_cout : (w_sign ^ w_ov);
  assign w_ovf = r_uns ? 1'b0 : w_ov;
`else
  assign w_lt  = w_sign ^ w_ov;
  assign w_ovf = w_ov;
`endif

  // Control FSM and datapath: accept, per-chunk add with carry, final result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_nb    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
`ifdef SLT_UNSIGNED_EN
      r_uns   <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_a     <= a;
            r_nb    <= ~b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
`ifdef SLT_UNSIGNED_EN
            r_uns   <= is_unsigned;
`endif
            busy    <= 1'b1;
            r_state <= S_BUSY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_carry <= w_cout;
          if (w_last) begin
            r       <= {{(WIDTH-1){1'b0}}, w_lt};
            ovf     <= w_ovf;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
